// File: rtl/hazard_unit_mc.sv
// -----------------------------------------------------------------------------
// hazard_unit_mc
//
// Hazard detection and forwarding controller for the in-order RISC-V pipeline,
// placed beside the ID stage. It checks FWD_STAGES downstream stages for RAW
// hazards, forwards from the nearest ready producer, and stalls on a not-ready
// producer. It also tracks one outstanding multi-cycle (MUL/DIV) operation with
// a scoreboard and countdown. A taken branch opens a flush window on the
// IF/ID register.
//
// Ports
//   clk, rst                       clock (rising edge), async active-low reset
//   rs1use_ID, rs2use_ID           ID instruction reads rs1 / rs2
//   rs1_ID, rs2_ID, rd_ID          ID register fields
//   regw_ID                        ID instruction writes rd_ID
//   issue_mc_ID                    ID instruction is a multi-cycle op
//   branch_taken_ID                branch/jump resolved taken in ID
//   rd_stg[5i+4:5i]                destination register of stage i (0 = EXE)
//   regw_stg[i], rdy_stg[i]        stage i writes rd / has its result ready
//   PC_EN_IF, reg_*_EN             pipeline enables
//   reg_FD_stall, reg_*_flush      stall / flush controls
//   forward_ctrl_A/B               0 = register file, k = stage k-1
//   mc_busy, mc_done, mc_rd        multi-cycle op status
//   stall_cnt                      stall cycle counter (HDU_STALL_STATS_EN only)
//
// Optional feature: define HDU_STALL_STATS_EN to add the 32-bit saturating
// stall_cnt output.
// -----------------------------------------------------------------------------
module hazard_unit_mc #(
  parameter int FWD_STAGES   = 3,
  parameter int MC_LAT       = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int FWD_W        = $clog2(FWD_STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rs1use_ID,
  input  logic                    rs2use_ID,
  input  logic [4:0]              rs1_ID,
  input  logic [4:0]              rs2_ID,
  input  logic [4:0]              rd_ID,
  input  logic                    regw_ID,
  input  logic                    issue_mc_ID,
  input  logic                    branch_taken_ID,
  input  logic [5*FWD_STAGES-1:0] rd_stg,
  input  logic [FWD_STAGES-1:0]   regw_stg,
  input  logic [FWD_STAGES-1:0]   rdy_stg,
  output logic                    PC_EN_IF,
  output logic                    reg_FD_EN,
  output logic                    reg_DE_EN,
  output logic                    reg_EM_EN,
  output logic                    reg_MW_EN,
  output logic                    reg_FD_stall,
  output logic                    reg_FD_flush,
  output logic                    reg_DE_flush,
  output logic                    reg_EM_flush,
  output logic [FWD_W-1:0]        forward_ctrl_A,
  output logic [FWD_W-1:0]        forward_ctrl_B,
  output logic                    mc_busy,
  output logic                    mc_done,
  output logic [4:0]              mc_rd
`ifdef HDU_STALL_STATS_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MC_LAT);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);
  localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       mc_rd_q, mc_rd_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;

  logic [FWD_STAGES-1:0] match_a_s, match_b_s;
  logic                  hit_a_s, hit_b_s;
  logic                  rdy_a_s, rdy_b_s;
  logic [FWD_W-1:0]      idx_a_s, idx_b_s;
  logic                  dstall_s;
  logic                  sb_stall_s;
  logic                  stall_s;
  logic                  busy_s;
  logic                  done_s;
  logic                  flush_s;

  assign busy_s = (state_q == BUSY);

  // Per-stage match and nearest-producer selection for both operands.
  always_comb begin
    match_a_s = {FWD_STAGES{1'b0}};
    match_b_s = {FWD_STAGES{1'b0}};
    hit_a_s   = 1'b0;
    hit_b_s   = 1'b0;
    rdy_a_s   = 1'b0;
    rdy_b_s   = 1'b0;
    idx_a_s   = {FWD_W{1'b0}};
    idx_b_s   = {FWD_W{1'b0}};
    // Walk from the farthest stage inward so the nearest match overwrites.
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      match_a_s[i] = rs1use_ID && regw_stg[i] &&
                     (rd_stg[5*i +: 5] != 5'd0) && (rd_stg[5*i +: 5] == rs1_ID);
      match_b_s[i] = rs2use_ID && regw_stg[i] &&
                     (rd_stg[5*i +: 5] != 5'd0) && (rd_stg[5*i +: 5] == rs2_ID);
      hit_a_s = hit_a_s | match_a_s[i];
      hit_b_s = hit_b_s | match_b_s[i];
      rdy_a_s = match_a_s[i] ? rdy_stg[i] : rdy_a_s;
      rdy_b_s = match_b_s[i] ? rdy_stg[i] : rdy_b_s;
      idx_a_s = match_a_s[i] ? FWD_W'(i + 1) : idx_a_s;
      idx_b_s = match_b_s[i] ? FWD_W'(i + 1) : idx_b_s;
    end
  end

  // Data stall, scoreboard stall and the combined, reset-gated stall.
  always_comb begin
    dstall_s   = (hit_a_s && !rdy_a_s) || (hit_b_s && !rdy_b_s);
    sb_stall_s = busy_s &&
                 ((rs1use_ID && (rs1_ID == mc_rd_q) && (mc_rd_q != 5'd0)) ||
                  (rs2use_ID && (rs2_ID == mc_rd_q) && (mc_rd_q != 5'd0)) ||
                  (regw_ID && (rd_ID == mc_rd_q)) ||
                  issue_mc_ID);
    stall_s    = rst && (dstall_s || sb_stall_s);
  end

  // Multi-cycle FSM next state, countdown and completion pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_rd_d = mc_rd_q;
    done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_mc_ID && !stall_s) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          mc_rd_d = rd_ID;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          done_s  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Flush window: a resolved taken branch reloads the window counter.
  always_comb begin
    if (branch_taken_ID && !stall_s) begin
      fcnt_d = FC_LOAD;
    end else if (fcnt_q != {FC_W{1'b0}}) begin
      fcnt_d = fcnt_q - {{(FC_W-1){1'b0}}, 1'b1};
    end else begin
      fcnt_d = fcnt_q;
    end
    flush_s = rst && !stall_s && (branch_taken_ID || (fcnt_q != {FC_W{1'b0}}));
  end

  // State, countdown, scoreboard register and flush counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      mc_rd_q <= 5'd0;
      fcnt_q  <= {FC_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_rd_q <= mc_rd_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef HDU_STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  // Outputs; combinational paths are gated so reset forces reset values.
  assign PC_EN_IF       = !stall_s;
  assign reg_FD_EN      = 1'b1;
  assign reg_DE_EN      = 1'b1;
  assign reg_EM_EN      = 1'b1;
  assign reg_MW_EN      = 1'b1;
  assign reg_FD_stall   = stall_s;
  assign reg_DE_flush   = stall_s;
  assign reg_FD_flush   = flush_s;
  assign reg_EM_flush   = 1'b0;
  assign forward_ctrl_A = (rst && hit_a_s && rdy_a_s) ? idx_a_s : {FWD_W{1'b0}};
  assign forward_ctrl_B = (rst && hit_b_s && rdy_b_s) ? idx_b_s : {FWD_W{1'b0}};
  assign mc_busy        = rst && busy_s;
  assign mc_done        = rst && done_s;
  assign mc_rd          = rst ? mc_rd_q : 5'd0;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit_mc
//
// Directed bench for hazard_unit_mc (FWD_STAGES=3, MC_LAT=4, FLUSH_CYCLES=2).
// A vector table covers the forwarding/stall combinational rules; short
// hand-written sequences cover the multi-cycle op, flush window and reset.
// -----------------------------------------------------------------------------
module tb_hazard_unit_mc;

  localparam int FWD_STAGES   = 3;
  localparam int MC_LAT       = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int FWD_W        = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    rs1use_ID, rs2use_ID;
  logic [4:0]              rs1_ID, rs2_ID, rd_ID;
  logic                    regw_ID, issue_mc_ID, branch_taken_ID;
  logic [5*FWD_STAGES-1:0] rd_stg;
  logic [FWD_STAGES-1:0]   regw_stg, rdy_stg;
  logic                    PC_EN_IF, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN;
  logic                    reg_FD_stall, reg_FD_flush, reg_DE_flush, reg_EM_flush;
  logic [FWD_W-1:0]        forward_ctrl_A, forward_ctrl_B;
  logic                    mc_busy, mc_done;
  logic [4:0]              mc_rd;
`ifdef HDU_STALL_STATS_EN
  logic [31:0]             stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  hazard_unit_mc #(
    .FWD_STAGES  (FWD_STAGES),
    .MC_LAT      (MC_LAT),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .FWD_W       (FWD_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rs1use_ID      (rs1use_ID),
    .rs2use_ID      (rs2use_ID),
    .rs1_ID         (rs1_ID),
    .rs2_ID         (rs2_ID),
    .rd_ID          (rd_ID),
    .regw_ID        (regw_ID),
    .issue_mc_ID    (issue_mc_ID),
    .branch_taken_ID(branch_taken_ID),
    .rd_stg         (rd_stg),
    .regw_stg       (regw_stg),
    .rdy_stg        (rdy_stg),
    .PC_EN_IF       (PC_EN_IF),
    .reg_FD_EN      (reg_FD_EN),
    .reg_DE_EN      (reg_DE_EN),
    .reg_EM_EN      (reg_EM_EN),
    .reg_MW_EN      (reg_MW_EN),
    .reg_FD_stall   (reg_FD_stall),
    .reg_FD_flush   (reg_FD_flush),
    .reg_DE_flush   (reg_DE_flush),
    .reg_EM_flush   (reg_EM_flush),
    .forward_ctrl_A (forward_ctrl_A),
    .forward_ctrl_B (forward_ctrl_B),
    .mc_busy        (mc_busy),
    .mc_done        (mc_done),
    .mc_rd          (mc_rd)
`ifdef HDU_STALL_STATS_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rs1use, rs2use;
    logic [4:0] rs1, rs2;
    logic [4:0] rd2, rd1, rd0;
    logic [2:0] regw, rdy;
    logic       br;
    logic [1:0] fa, fb;
    logic       stall;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input string n, input logic u1, input logic u2,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] d2, input logic [4:0] d1, input logic [4:0] d0,
                              input logic [2:0] w, input logic [2:0] y, input logic b,
                              input logic [1:0] ea, input logic [1:0] eb, input logic es);
    vec_t v;
    v.name = n; v.rs1use = u1; v.rs2use = u2; v.rs1 = r1; v.rs2 = r2;
    v.rd2 = d2; v.rd1 = d1; v.rd0 = d0; v.regw = w; v.rdy = y; v.br = b;
    v.fa = ea; v.fb = eb; v.stall = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle; checks happen on the falling edge.
  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    rs1use_ID = 1'b0; rs2use_ID = 1'b0; rs1_ID = 5'd0; rs2_ID = 5'd0;
    rd_ID = 5'd0; regw_ID = 1'b0; issue_mc_ID = 1'b0; branch_taken_ID = 1'b0;
    rd_stg = 15'd0; regw_stg = 3'b000; rdy_stg = 3'b000;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pc_en"},    {31'd0, PC_EN_IF}, 32'd1);
    chk({tag, "_enables"},  {28'd0, reg_FD_EN, reg_DE_EN, reg_EM_EN, reg_MW_EN}, 32'hF);
    chk({tag, "_stall"},    {31'd0, reg_FD_stall}, 32'd0);
    chk({tag, "_flushes"},  {29'd0, reg_FD_flush, reg_DE_flush, reg_EM_flush}, 32'd0);
    chk({tag, "_fwd"},      {28'd0, forward_ctrl_A, forward_ctrl_B}, 32'd0);
    chk({tag, "_mc"},       {25'd0, mc_busy, mc_done, mc_rd}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk("exe_fwd",        1, 0,  5, 0,  0, 0, 5, 3'b001, 3'b001, 0, 2'd1, 2'd0, 0);
    vecs[1]  = mk("load_use",       0, 1,  0, 7,  0, 7, 7, 3'b011, 3'b010, 0, 2'd0, 2'd0, 1);
    vecs[2]  = mk("mem_fwd_b",      0, 1,  0, 7,  0, 7, 3, 3'b011, 3'b011, 0, 2'd0, 2'd2, 0);
    vecs[3]  = mk("wb_fwd_a",       1, 0, 12, 0, 12, 0, 0, 3'b100, 3'b100, 0, 2'd3, 2'd0, 0);
    vecs[4]  = mk("x0_nofwd",       1, 1,  0, 0,  0, 0, 0, 3'b111, 3'b111, 0, 2'd0, 2'd0, 0);
    vecs[5]  = mk("no_use",         0, 0,  5, 5,  5, 5, 5, 3'b111, 3'b111, 0, 2'd0, 2'd0, 0);
    vecs[6]  = mk("skip_noregw",    1, 0,  5, 0,  0, 5, 5, 3'b010, 3'b011, 0, 2'd2, 2'd0, 0);
    vecs[7]  = mk("both_ops",       1, 1,  4, 6,  6, 0, 4, 3'b101, 3'b101, 0, 2'd1, 2'd3, 0);
    vecs[8]  = mk("far_notrdy",     1, 0,  8, 0,  8, 0, 0, 3'b100, 3'b000, 0, 2'd0, 2'd0, 1);
    vecs[9]  = mk("notrdy_noregw",  1, 0,  8, 0,  0, 0, 8, 3'b000, 3'b000, 0, 2'd0, 2'd0, 0);
    vecs[10] = mk("rd_mismatch",    1, 0,  5, 0,  0, 0, 6, 3'b001, 3'b001, 0, 2'd0, 2'd0, 0);
    vecs[11] = mk("br_under_stall", 0, 1,  0, 7,  0, 7, 7, 3'b011, 3'b010, 1, 2'd0, 2'd0, 1);
    vecs[12] = mk("after_br_stall", 1, 0,  5, 0,  0, 0, 5, 3'b001, 3'b001, 0, 2'd1, 2'd0, 0);

    // Reset forces outputs even with hazard-producing inputs present.
    rst = 1'b0;
    idle_inputs();
    rs1use_ID = 1'b1; rs1_ID = 5'd5; rs2use_ID = 1'b1; rs2_ID = 5'd7;
    rd_stg = {5'd0, 5'd7, 5'd5}; regw_stg = 3'b011; rdy_stg = 3'b001;
    issue_mc_ID = 1'b1; branch_taken_ID = 1'b1;
    #3;
    chk_reset_outs("rst0");
    tick();
    settle();
    chk_reset_outs("rst1");
    tick();
    rst = 1'b1;
    idle_inputs();
    settle();
    chk("post_rst_pc_en", {31'd0, PC_EN_IF}, 32'd1);

    // Table-driven forwarding and stall vectors.
    for (int i = 0; i < 13; i++) begin
      tick();
      rs1use_ID = vecs[i].rs1use; rs2use_ID = vecs[i].rs2use;
      rs1_ID = vecs[i].rs1; rs2_ID = vecs[i].rs2;
      rd_stg = {vecs[i].rd2, vecs[i].rd1, vecs[i].rd0};
      regw_stg = vecs[i].regw; rdy_stg = vecs[i].rdy;
      branch_taken_ID = vecs[i].br;
      settle();
      chk({vecs[i].name, "_fa"},    {30'd0, forward_ctrl_A}, {30'd0, vecs[i].fa});
      chk({vecs[i].name, "_fb"},    {30'd0, forward_ctrl_B}, {30'd0, vecs[i].fb});
      chk({vecs[i].name, "_pc_en"}, {31'd0, PC_EN_IF},       {31'd0, ~vecs[i].stall});
      chk({vecs[i].name, "_fd_st"}, {31'd0, reg_FD_stall},   {31'd0, vecs[i].stall});
      chk({vecs[i].name, "_de_fl"}, {31'd0, reg_DE_flush},   {31'd0, vecs[i].stall});
      chk({vecs[i].name, "_fd_fl"}, {31'd0, reg_FD_flush},   32'd0);
    end

    // Multi-cycle RAW: issue rd=9, dependent reader stalls through mc_done.
    tick();
    idle_inputs();
    issue_mc_ID = 1'b1; regw_ID = 1'b1; rd_ID = 5'd9;
    settle();
    chk("raw_issue_pc_en", {31'd0, PC_EN_IF}, 32'd1);
    chk("raw_issue_busy",  {31'd0, mc_busy},  32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        issue_mc_ID = 1'b0; regw_ID = 1'b0; rd_ID = 5'd0;
        rs1use_ID = 1'b1; rs1_ID = 5'd9;
      end
      settle();
      chk($sformatf("raw_pc_en_%0d", k), {31'd0, PC_EN_IF}, {31'd0, (k == 5)});
      chk($sformatf("raw_de_fl_%0d", k), {31'd0, reg_DE_flush}, {31'd0, (k != 5)});
      chk($sformatf("raw_busy_%0d", k),  {31'd0, mc_busy},  {31'd0, (k <= 4)});
      chk($sformatf("raw_done_%0d", k),  {31'd0, mc_done},  {31'd0, (k == 4)});
      if (k <= 4) chk($sformatf("raw_mc_rd_%0d", k), {27'd0, mc_rd}, 32'd9);
    end

    // Back-to-back issue: second op held until IDLE, accepted after mc_done.
    tick();
    idle_inputs();
    issue_mc_ID = 1'b1; regw_ID = 1'b1; rd_ID = 5'd10;
    settle();
    chk("b2b_first_busy", {31'd0, mc_busy}, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) rd_ID = 5'd11;
      if (k == 6) begin
        issue_mc_ID = 1'b0; regw_ID = 1'b0; rd_ID = 5'd0;
      end
      settle();
      chk($sformatf("b2b_pc_en_%0d", k), {31'd0, PC_EN_IF}, {31'd0, (k >= 5)});
      chk($sformatf("b2b_busy_%0d", k),  {31'd0, mc_busy},
          {31'd0, ((k <= 4) || ((k >= 6) && (k <= 9)))});
      chk($sformatf("b2b_done_%0d", k),  {31'd0, mc_done}, {31'd0, ((k == 4) || (k == 9))});
      if (k == 6) chk("b2b_second_rd", {27'd0, mc_rd}, 32'd11);
    end

    // Flush window of FLUSH_CYCLES=2 from a single taken branch.
    for (int k = 0; k < 4; k++) begin
      tick();
      idle_inputs();
      branch_taken_ID = (k == 0);
      settle();
      chk($sformatf("flush1_%0d", k), {31'd0, reg_FD_flush}, {31'd0, (k < 2)});
    end

    // Second branch inside the window reloads it.
    for (int k = 0; k < 4; k++) begin
      tick();
      branch_taken_ID = (k < 2);
      settle();
      chk($sformatf("flush2_%0d", k), {31'd0, reg_FD_flush}, {31'd0, (k < 3)});
    end

    // An open window is masked while a stall is asserted.
    tick();
    branch_taken_ID = 1'b1;
    settle();
    chk("flush3_open", {31'd0, reg_FD_flush}, 32'd1);
    tick();
    branch_taken_ID = 1'b0;
    rs2use_ID = 1'b1; rs2_ID = 5'd7; rd_stg = {5'd0, 5'd0, 5'd7};
    regw_stg = 3'b001; rdy_stg = 3'b000;
    settle();
    chk("flush3_stall_st", {31'd0, reg_FD_stall}, 32'd1);
    chk("flush3_stall_fl", {31'd0, reg_FD_flush}, 32'd0);
    tick();
    idle_inputs();
    tick();

    // Reset in the middle of a multi-cycle op.
    idle_inputs();
    issue_mc_ID = 1'b1; regw_ID = 1'b1; rd_ID = 5'd9;
    settle();
    tick();
    issue_mc_ID = 1'b0; regw_ID = 1'b0; rd_ID = 5'd0;
    rs1use_ID = 1'b1; rs1_ID = 5'd9;
    rs2use_ID = 1'b1; rs2_ID = 5'd3;
    rd_stg = {5'd0, 5'd0, 5'd3}; regw_stg = 3'b001; rdy_stg = 3'b001;
    settle();
    chk("mid_pre_pc_en", {31'd0, PC_EN_IF}, 32'd0);
    chk("mid_pre_busy",  {31'd0, mc_busy},  32'd1);
    rst = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    tick();
    settle();
    chk_reset_outs("mid_rst_edge");
    tick();
    rst = 1'b1;
    idle_inputs();
    for (int k = 1; k <= 6; k++) begin
      settle();
      chk($sformatf("mid_after_%0d", k), {30'd0, mc_busy, mc_done}, 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
